keypad_entry: RTL and testbench

KEYPAD_ENTRY -- requirements
Module: keypad_entry

---
 rtl/keypad_entry.sv | 186 ++++++++++++++++++
 tb/tb_keypad_entry.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/keypad_entry.sv
// keypad_entry: debounced ten-key digit entry for a cooker timer.
// Each accepted key press shifts one digit into an M:ST:SO time display.
//
// State table
//   state      | meaning
//   IDLE       | no key down; waiting for a non-zero keypad sample
//   PRESS_DB   | pattern latched; counting identical samples until accepted
//   HELD       | press accepted; ignoring activity until all keys released
//   RELEASE_DB | counting consecutive all-zero samples before re-arming
//
// Ports
//   clock        system clock, rising edge
//   clearn       asynchronous active-low reset
//   keypad       raw key lines, bit k = digit k, asynchronous to clock
//   entry_en     high = accepted presses update the time
//   clr_digits   synchronous clear of the entered time
//   mins         BCD minutes digit
//   sec_tens     BCD tens-of-seconds digit
//   sec_ones     BCD ones-of-seconds digit
//   key_valid    one-cycle pulse when a digit is shifted in
//   key_reject   one-cycle pulse when a press is refused by the range rule
//   time_nonzero high when any digit is non-zero
module keypad_entry #(
    parameter int DEBOUNCE_CYCLES = 3
) (
    input  logic       clock,
    input  logic       clearn,
    input  logic [9:0] keypad,
    input  logic       entry_en,
    input  logic       clr_digits,
    output logic [3:0] mins,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       key_valid,
    output logic       key_reject,
    output logic       time_nonzero
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } state_t;

    localparam logic [3:0] DB_LIMIT = 4'(DEBOUNCE_CYCLES);

    logic [9:0] kp_meta;
    logic [9:0] kp_sync;
    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;
    logic [3:0] cnt_inc;
    logic [9:0] pat;
    logic [9:0] pat_nxt;
    logic       accept;
    logic [3:0] digit;

    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            kp_meta <= '0;
            kp_sync <= '0;
        end else begin
            kp_meta <= keypad;
            kp_sync <= kp_meta;
        end
    end

    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            state <= IDLE;
            cnt   <= '0;
            pat   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            pat   <= pat_nxt;
        end
    end

    assign cnt_inc = cnt + 4'd1;

    // The counter holds the number of qualifying samples seen so far, so the
    // first sample counts as 1 and a limit of 1 accepts/releases immediately.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pat_nxt   = pat;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (kp_sync != '0) begin
                    pat_nxt = kp_sync;
                    cnt_nxt = 4'd1;
                    if (DB_LIMIT <= 4'd1) begin
                        state_nxt = HELD;
                        accept    = 1'b1;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = PRESS_DB;
                    end
                end
            end
            PRESS_DB: begin
                if (kp_sync != pat) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt_inc >= DB_LIMIT) begin
                    state_nxt = HELD;
                    accept    = 1'b1;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            HELD: begin
                if (kp_sync == '0) begin
                    if (DB_LIMIT <= 4'd1) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = RELEASE_DB;
                        cnt_nxt   = 4'd1;
                    end
                end
            end
            RELEASE_DB: begin
                if (kp_sync != '0) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else if (cnt_inc >= DB_LIMIT) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Acceptance only happens while kp_sync equals the latched pattern (or is
    // the first sample), so encoding kp_sync gives the pressed digit.
    always_comb begin
        digit = '0;
        for (int k = 0; k < 10; k++) begin
            if (kp_sync[k]) digit = 4'(k);
        end
    end

    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            mins       <= '0;
            sec_tens   <= '0;
            sec_ones   <= '0;
            key_valid  <= 1'b0;
            key_reject <= 1'b0;
        end else begin
            key_valid  <= 1'b0;
            key_reject <= 1'b0;
            if (accept && entry_en) begin
                // A ones digit above 5 would become an illegal tens-of-seconds.
                if (sec_ones > 4'd5) begin
                    key_reject <= 1'b1;
                end else begin
                    key_valid <= 1'b1;
                    mins      <= sec_tens;
                    sec_tens  <= sec_ones;
                    sec_ones  <= digit;
                end
            end
            if (clr_digits) begin
                mins     <= '0;
                sec_tens <= '0;
                sec_ones <= '0;
            end
        end
    end

    assign time_nonzero = (mins != '0) || (sec_tens != '0) || (sec_ones != '0);

endmodule

// File: tb/tb_keypad_entry.sv
// tb_keypad_entry: directed scenarios plus randomized press/gap episodes
// for keypad_entry, checked against a segment-level behavioural model.
module tb_keypad_entry;

    localparam int DB = 3;

    logic       clock;
    logic       clearn;
    logic [9:0] keypad;
    logic       entry_en;
    logic       clr_digits;
    logic [3:0] mins;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       key_valid;
    logic       key_reject;
    logic       time_nonzero;

    int checks   = 0;
    int failures = 0;
    int vcnt     = 0;
    int rcnt     = 0;

    keypad_entry #(.DEBOUNCE_CYCLES(DB)) dut (
        .clock        (clock),
        .clearn       (clearn),
        .keypad       (keypad),
        .entry_en     (entry_en),
        .clr_digits   (clr_digits),
        .mins         (mins),
        .sec_tens     (sec_tens),
        .sec_ones     (sec_ones),
        .key_valid    (key_valid),
        .key_reject   (key_reject),
        .time_nonzero (time_nonzero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (key_valid === 1'b1) vcnt++;
        if (key_reject === 1'b1) rcnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [9:0] p, input int hold, input int gap);
        keypad = p;
        tick(hold);
        keypad = '0;
        tick(gap);
    endtask

    task automatic clear_pulse();
        clr_digits = 1'b1;
        tick(1);
        clr_digits = 1'b0;
    endtask

    function automatic logic [3:0] top_digit(input logic [9:0] p);
        logic [3:0] d = 0;
        for (int k = 0; k < 10; k++) if (p[k]) d = 4'(k);
        return d;
    endfunction

    initial begin
        int v0, r0;
        logic [3:0] m_m, m_t, m_o;
        int m_v, m_r;
        logic armed;
        logic en;
        logic [9:0] p;
        int nseg, len, gap;

        clearn = 1'b0; keypad = '0; entry_en = 1'b1; clr_digits = 1'b0;
        tick(3);
        check("reset_digits", {mins, sec_tens, sec_ones}, 12'h000);
        check("reset_pulses", {key_valid, key_reject}, 2'b00);
        check("reset_nonzero", time_nonzero, 1'b0);
        clearn = 1'b1;
        tick(2);

        // single press of key 2
        v0 = vcnt;
        press(10'b0000000100, 10, 10);
        check("k2_valid_count", vcnt - v0, 1);
        check("k2_sec_ones", sec_ones, 4'd2);
        check("k2_nonzero", time_nonzero, 1'b1);

        // 1, 3, 0 sequence
        clear_pulse();
        check("clr_before_seq", {mins, sec_tens, sec_ones}, 12'h000);
        v0 = vcnt;
        press(10'b0000000010, 10, 10);
        press(10'b0000001000, 10, 10);
        press(10'b0000000001, 10, 10);
        check("seq_digits", {mins, sec_tens, sec_ones}, 12'h130);
        check("seq_valid_count", vcnt - v0, 3);

        // two-cycle glitch on key 5
        v0 = vcnt; r0 = rcnt;
        keypad = 10'b0000100000;
        tick(2);
        keypad = '0;
        tick(10);
        check("glitch_pulses", (vcnt - v0) + (rcnt - r0), 0);
        check("glitch_digits", {mins, sec_tens, sec_ones}, 12'h130);

        // 7 then 4 -> range reject
        clear_pulse();
        v0 = vcnt; r0 = rcnt;
        press(10'b0010000000, 10, 10);
        press(10'b0000010000, 10, 10);
        check("rej_digits", {mins, sec_tens, sec_ones}, 12'h007);
        check("rej_valid_count", vcnt - v0, 1);
        check("rej_reject_count", rcnt - r0, 1);

        // multi-key pattern resolves to highest index, then clear
        clear_pulse();
        press(10'b1000000010, 10, 10);
        check("multi_sec_ones", sec_ones, 4'd9);
        clear_pulse();
        check("clr_digits", {mins, sec_tens, sec_ones}, 12'h000);
        check("clr_nonzero", time_nonzero, 1'b0);

        // reset mid-hold on key 3
        keypad = 10'b0000001000;
        tick(10);
        check("pre_reset_ones", sec_ones, 4'd3);
        v0 = vcnt;
        clearn = 1'b0;
        #1;
        check("async_rst_digits", {mins, sec_tens, sec_ones}, 12'h000);
        check("async_rst_nonzero", time_nonzero, 1'b0);
        tick(2);
        clearn = 1'b1;
        tick(15);
        keypad = '0;
        tick(10);
        check("post_rst_ones", sec_ones, 4'd3);
        check("post_rst_valid_count", vcnt - v0, 1);

        // randomized episodes against a press/gap segment model
        clear_pulse();
        m_m = 0; m_t = 0; m_o = 0;
        for (int ep = 0; ep < 30; ep++) begin
            en = 1'($urandom_range(0, 1));
            entry_en = en;
            v0 = vcnt; r0 = rcnt;
            m_v = 0; m_r = 0;
            armed = 1'b1;
            nseg = $urandom_range(1, 4);
            for (int s = 0; s < nseg; s++) begin
                p   = 10'($urandom_range(1, 1023));
                len = $urandom_range(1, 6);
                gap = $urandom_range(1, 5);
                if (armed && len >= DB) begin
                    armed = 1'b0;
                    if (en) begin
                        if (m_o > 5) m_r++;
                        else begin
                            m_m = m_t; m_t = m_o; m_o = top_digit(p);
                            m_v++;
                        end
                    end
                end
                if (gap >= DB) armed = 1'b1;
                press(p, len, gap);
            end
            tick(10);
            check("rnd_digits", {mins, sec_tens, sec_ones}, {m_m, m_t, m_o});
            check("rnd_valid_count", vcnt - v0, m_v);
            check("rnd_reject_count", rcnt - r0, m_r);
            if ($urandom_range(0, 3) == 0) begin
                clear_pulse();
                m_m = 0; m_t = 0; m_o = 0;
                check("rnd_clr_nonzero", time_nonzero, 1'b0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
